// File: rtl/mem_bridge.sv
// Core fetch/load/store port to a single SRAM with a gnt/rvalid handshake; read 4 cycles, store 3 at zero wait.
// Stalls the core via dbusy; misaligned or timed-out accesses finish with a one-cycle err pulse.
module mem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_type,
  input  logic        mem_sign,
  input  logic        rimem,
  input  logic        rdmem,
  input  logic        wmem,
  output logic [31:0] mem_rdata,
  output logic        dbusy,
  output logic        err,
  output logic        sram_req,
  output logic        sram_we,
  output logic [29:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_be,
  input  logic        sram_gnt,
  input  logic        sram_rvalid,
  input  logic [31:0] sram_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_n;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  type_q;
  logic        sign_q, store_q, fault_q;
  logic [7:0]  cnt_q;

  logic        any_req, req_store, req_sign, req_misal;
  logic [1:0]  req_type;
  logic        timeout, set_fault, read_fault;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_fmt, wdata_fmt;
  logic [3:0]  be_fmt;

  assign any_req = rimem | rdmem | wmem;

  // A fetch only wins when no data access is present; it is always an unsigned word.
  always_comb begin
    req_store = wmem;
    req_type  = mem_type;
    req_sign  = mem_sign;
    if (!wmem && !rdmem) begin
      req_type = 2'b10;
      req_sign = 1'b0;
    end
    req_misal = 1'b0;
    if (req_type == 2'b01)
      req_misal = mem_addr[0];
    else if (req_type[1])
      req_misal = |mem_addr[1:0];
  end

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_n   = state;
    set_fault = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_n   = req_misal ? DONE : REQ;
          set_fault = req_misal;
        end
      end
      REQ: begin
        if (sram_gnt)
          state_n = store_q ? DONE : WAIT_R;
        else if (timeout) begin
          state_n   = DONE;
          set_fault = 1'b1;
        end
      end
      WAIT_R: begin
        if (sram_rvalid)
          state_n = DONE;
        else if (timeout) begin
          state_n   = DONE;
          set_fault = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign read_fault = set_fault && ((state == IDLE) ? !req_store : !store_q);

  always_comb begin
    case (type_q)
      2'b00: begin
        be_fmt    = 4'b0001 << addr_q[1:0];
        wdata_fmt = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << {addr_q[1], 1'b0};
        wdata_fmt = {2{wdata_q[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = wdata_q;
      end
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   rd_byte = sram_rdata[7:0];
      2'b01:   rd_byte = sram_rdata[15:8];
      2'b10:   rd_byte = sram_rdata[23:16];
      default: rd_byte = sram_rdata[31:24];
    endcase
    rd_half = addr_q[1] ? sram_rdata[31:16] : sram_rdata[15:0];
    case (type_q)
      2'b00:   load_fmt = {{24{sign_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_fmt = {{16{sign_q & rd_half[15]}}, rd_half};
      default: load_fmt = sram_rdata;
    endcase
  end

  assign dbusy      = (state == IDLE && any_req) || state == REQ || state == WAIT_R;
  assign sram_req   = (state == REQ);
  assign sram_we    = (state == REQ) && store_q;
  assign sram_be    = (state == REQ) ? be_fmt : 4'b0000;
  assign sram_addr  = addr_q[31:2];
  assign sram_wdata = wdata_fmt;
  assign err        = (state == DONE) && fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Counter restarts on every state change, so it times REQ and WAIT_R separately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= 8'd0;
    else if (state_n != state)
      cnt_q <= 8'd0;
    else if (state == REQ || state == WAIT_R)
      cnt_q <= cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      type_q  <= 2'b00;
      sign_q  <= 1'b0;
      store_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= set_fault;
      if (state == IDLE && any_req) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
        type_q  <= req_type;
        sign_q  <= req_sign;
        store_q <= req_store;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_rdata <= 32'd0;
    else if (state == WAIT_R && sram_rvalid)
      mem_rdata <= load_fmt;
    else if (read_fault)
      mem_rdata <= 32'd0;
  end
endmodule

// File: tb/tb_mem_bridge.sv
// Table-driven bench for mem_bridge with a small SRAM responder and an expected-result queue.
module tb_mem_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
  logic [1:0]  mem_type;
  logic        mem_sign, rimem, rdmem, wmem, dbusy, err;
  logic        sram_req, sram_we, sram_gnt, sram_rvalid;
  logic [29:0] sram_addr;
  logic [3:0]  sram_be;

  int n_pass = 0;
  int n_total = 0;

  mem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_sign(mem_sign),
    .rimem(rimem), .rdmem(rdmem), .wmem(wmem),
    .mem_rdata(mem_rdata), .dbusy(dbusy), .err(err),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_be(sram_be),
    .sram_gnt(sram_gnt), .sram_rvalid(sram_rvalid), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // mode: 0 immediate gnt/rvalid, 1 gnt never, 2 rvalid never, 3 gnt on third request cycle
  typedef struct {
    bit rim; bit rdm; bit wm;
    logic [31:0] addr; logic [31:0] wdata; logic [1:0] typ; bit sgn;
    logic [31:0] word; int mode; int lat; int reqc;
    bit we; logic [3:0] be; logic [31:0] wdat; logic [31:0] rdata; bit e;
  } vec_t;

  typedef struct { logic [31:0] rdata; bit e; } exp_t;

  vec_t vecs[20];
  exp_t sb_q[$];

  function automatic vec_t mk(bit rim, bit rdm, bit wm, logic [31:0] addr, logic [31:0] wdata,
                              logic [1:0] typ, bit sgn, logic [31:0] word, int mode, int lat,
                              int reqc, bit we, logic [3:0] be, logic [31:0] wdat,
                              logic [31:0] rdata, bit e);
    vec_t v;
    v.rim = rim; v.rdm = rdm; v.wm = wm; v.addr = addr; v.wdata = wdata; v.typ = typ;
    v.sgn = sgn; v.word = word; v.mode = mode; v.lat = lat; v.reqc = reqc; v.we = we;
    v.be = be; v.wdat = wdat; v.rdata = rdata; v.e = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic idle_inputs();
    rimem = 0; rdmem = 0; wmem = 0; mem_addr = 0; mem_wdata = 0; mem_type = 0; mem_sign = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, reqc;
    bit done, err_early;
    exp_t e, got;
    @(negedge clk);
    rimem = v.rim; rdmem = v.rdm; wmem = v.wm; mem_addr = v.addr; mem_wdata = v.wdata;
    mem_type = v.typ; mem_sign = v.sgn;
    #1;
    check($sformatf("v%0d_cyc0_dbusy", idx), 32'(dbusy), 32'd1);
    check($sformatf("v%0d_cyc0_err", idx), 32'(err), 32'd0);
    e.rdata = v.rdata; e.e = v.e;
    sb_q.push_back(e);
    k = 0; reqc = 0; done = 0; err_early = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      idle_inputs();
      sram_gnt = 0; sram_rvalid = 0;
      #1;
      if (!dbusy) begin
        done = 1;
        got = sb_q.pop_front();
        check($sformatf("v%0d_rdata", idx), mem_rdata, got.rdata);
        check($sformatf("v%0d_err", idx), 32'(err), 32'(got.e));
        check($sformatf("v%0d_latency", idx), 32'(k), 32'(v.lat));
        check($sformatf("v%0d_req_cycles", idx), 32'(reqc), 32'(v.reqc));
        check($sformatf("v%0d_no_early_err", idx), 32'(err_early), 32'd0);
      end else begin
        if (err) err_early = 1;
        if (sram_req) begin
          reqc++;
          check($sformatf("v%0d_sram_addr", idx), 32'(sram_addr), 32'(v.addr[31:2]));
          check($sformatf("v%0d_sram_we", idx), 32'(sram_we), 32'(v.we));
          if (v.we) begin
            check($sformatf("v%0d_sram_be", idx), 32'(sram_be), 32'(v.be));
            check($sformatf("v%0d_sram_wdata", idx), sram_wdata, v.wdat);
          end
          if (v.mode == 0 || v.mode == 2 || (v.mode == 3 && reqc == 3)) sram_gnt = 1;
        end else if (v.mode != 2) begin
          sram_rvalid = 1;
          sram_rdata  = v.word;
        end
      end
    end
    if (!done) begin
      check($sformatf("v%0d_done_within_bound", idx), 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end
    sram_gnt = 0; sram_rvalid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0,1,0, 32'h103, 0,            2'b00,1, 32'h80FF_1234, 0,3,1, 0,4'h0,0,            32'hFFFF_FF80, 0);
    vecs[1]  = mk(0,0,1, 32'h202, 32'h0000_ABCD,2'b01,0, 0,             0,2,1, 1,4'hC,32'hABCD_ABCD,32'hFFFF_FF80, 0);
    vecs[2]  = mk(0,1,0, 32'h006, 0,            2'b10,0, 32'h1111_1111, 0,1,0, 0,4'h0,0,            32'h0000_0000, 1);
    vecs[3]  = mk(0,1,0, 32'h101, 0,            2'b00,0, 32'h80FF_1234, 0,3,1, 0,4'h0,0,            32'h0000_0012, 0);
    vecs[4]  = mk(0,1,0, 32'h002, 0,            2'b01,1, 32'h80FF_1234, 0,3,1, 0,4'h0,0,            32'hFFFF_80FF, 0);
    vecs[5]  = mk(0,1,0, 32'h000, 0,            2'b01,0, 32'h1234_F00D, 0,3,1, 0,4'h0,0,            32'h0000_F00D, 0);
    vecs[6]  = mk(0,0,1, 32'h011, 32'h1234_56A5,2'b00,0, 0,             0,2,1, 1,4'h2,32'hA5A5_A5A5,32'h0000_F00D, 0);
    vecs[7]  = mk(1,0,0, 32'h040, 0,            2'b00,1, 32'h8765_4321, 0,3,1, 0,4'h0,0,            32'h8765_4321, 0);
    vecs[8]  = mk(0,0,1, 32'h020, 32'hDEAD_BEEF,2'b10,0, 0,             0,2,1, 1,4'hF,32'hDEAD_BEEF,32'h8765_4321, 0);
    vecs[9]  = mk(0,0,1, 32'h033, 32'h0000_FFFF,2'b01,0, 0,             0,1,0, 1,4'h0,0,            32'h8765_4321, 1);
    vecs[10] = mk(0,1,0, 32'h002, 0,            2'b00,1, 32'h007F_0000, 0,3,1, 0,4'h0,0,            32'h0000_007F, 0);
    vecs[11] = mk(1,0,0, 32'h042, 0,            2'b00,0, 32'h2222_2222, 0,1,0, 0,4'h0,0,            32'h0000_0000, 1);
    vecs[12] = mk(0,1,1, 32'h010, 32'h55AA_55AA,2'b10,0, 32'h3333_3333, 0,2,1, 1,4'hF,32'h55AA_55AA,32'h0000_0000, 0);
    vecs[13] = mk(1,1,0, 32'h003, 0,            2'b00,0, 32'h80FF_1234, 0,3,1, 0,4'h0,0,            32'h0000_0080, 0);
    vecs[14] = mk(0,1,0, 32'h008, 0,            2'b10,0, 32'hCAFE_F00D, 3,5,3, 0,4'h0,0,            32'hCAFE_F00D, 0);
    vecs[15] = mk(0,1,0, 32'h008, 0,            2'b10,0, 32'h4444_4444, 1,5,4, 0,4'h0,0,            32'h0000_0000, 1);
    vecs[16] = mk(0,1,0, 32'h004, 0,            2'b10,0, 32'h1357_2468, 0,3,1, 0,4'h0,0,            32'h1357_2468, 0);
    vecs[17] = mk(0,0,1, 32'h024, 32'h0000_0001,2'b10,0, 0,             1,5,4, 1,4'hF,32'h0000_0001,32'h1357_2468, 1);
    vecs[18] = mk(0,1,0, 32'h004, 0,            2'b10,0, 32'h5555_5555, 2,6,1, 0,4'h0,0,            32'h0000_0000, 1);
    vecs[19] = mk(0,0,1, 32'h030, 32'h0000_00C3,2'b00,0, 0,             3,4,3, 1,4'h1,32'hC3C3_C3C3,32'h0000_0000, 0);

    idle_inputs();
    sram_gnt = 0; sram_rvalid = 0; sram_rdata = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_sram_req", 32'(sram_req), 32'd0);
    check("rst_sram_we", 32'(sram_we), 32'd0);
    check("rst_sram_be", 32'(sram_be), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_dbusy", 32'(dbusy), 32'd0);
    rst = 0;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Reset pulse while waiting for read data; the late rvalid must be ignored.
    @(negedge clk);
    rdmem = 1; mem_addr = 32'h8; mem_type = 2'b10;
    @(negedge clk);
    idle_inputs();
    #1;
    check("rstseq_req", 32'(sram_req), 32'd1);
    sram_gnt = 1;
    @(negedge clk);
    sram_gnt = 0;
    #1;
    check("rstseq_wait_busy", 32'(dbusy), 32'd1);
    check("rstseq_wait_noreq", 32'(sram_req), 32'd0);
    rst = 1;
    #1;
    check("rstseq_async_dbusy", 32'(dbusy), 32'd0);
    check("rstseq_async_rdata", mem_rdata, 32'd0);
    #1 rst = 0;
    @(negedge clk);
    sram_rvalid = 1; sram_rdata = 32'h1234_5678;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      sram_rvalid = 0;
      #1;
      check($sformatf("rstseq_rdata_%0d", j), mem_rdata, 32'd0);
      check($sformatf("rstseq_err_%0d", j), 32'(err), 32'd0);
      check($sformatf("rstseq_idle_%0d", j), 32'(dbusy), 32'd0);
    end
    check("rstseq_sb_empty", 32'(sb_q.size()), 32'd0);

    run_vec(vecs[0], 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles waited for sram_gnt or sram_rvalid before abort (8-bit counter).
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have core-side inputs: mem_addr 32 (byte address), mem_wdata 32, mem_type 2 (00 byte, 01 half, 10 word), mem_sign 1 (1 = sign-extend load), rimem 1 (instruction fetch), rdmem 1 (data load), wmem 1 (data store).
REQ-005 SHALL have core-side outputs: mem_rdata 32 (formatted read data), dbusy 1 (core stall), err 1 (one-cycle access-fault pulse).
REQ-006 SHALL have SRAM-side outputs: sram_req 1, sram_we 1, sram_addr 30 (word address = mem_addr[31:2]), sram_wdata 32, sram_be 4.
REQ-007 SHALL have SRAM-side inputs: sram_gnt 1 (request accepted), sram_rvalid 1 (read data valid), sram_rdata 32.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_R, DONE.
REQ-009 IDLE: any of rimem/rdmem/wmem high -> capture address, wdata, type, sign, kind into registers; go to REQ; dbusy SHALL be high combinationally in that same cycle.
REQ-010 Simultaneous requests SHALL be prioritised wmem > rdmem > rimem; lower-priority requests are dropped, not queued.
REQ-011 rimem SHALL always be a word read, unsigned; mem_type and mem_sign ignored.
REQ-012 Misaligned access (half with addr[0]=1; word with addr[1:0]!=0) SHALL go IDLE -> DONE, never assert sram_req, pulse err in DONE, set mem_rdata to 0 for reads.
REQ-013 REQ: sram_req=1, sram_we=1 for stores, held with stable addr/wdata/be until sram_gnt; on gnt a store goes to DONE, a read goes to WAIT_R.
REQ-014 WAIT_R: sram_req=0; on sram_rvalid, capture formatted data into mem_rdata, go to DONE; sram_rvalid outside WAIT_R SHALL be ignored.
REQ-015 DONE: dbusy=0 for exactly this cycle; return to IDLE unconditionally; requests present in DONE are ignored.
REQ-016 dbusy SHALL be 1 in REQ and WAIT_R, 0 in DONE and in IDLE with no request.
REQ-017 Store byte: sram_wdata = wdata[7:0] replicated x4, sram_be = 4'b0001 << addr[1:0].
REQ-018 Store half: sram_wdata = wdata[15:0] replicated x2, sram_be = 4'b0011 << {addr[1],1'b0}; store word: sram_be = 4'b1111.
REQ-019 Load byte/half: select lane by addr[1:0]/addr[1], sign- or zero-extend to 32 bits per captured mem_sign; word passes through.
REQ-020 mem_rdata SHALL be registered and hold its last value until the next read completes, faults, or times out; stores do not change it.
REQ-021 Timeout counter SHALL clear on entry to REQ and WAIT_R, increment each cycle in them; on reaching TIMEOUT_CYCLES go to DONE, drop sram_req, pulse err, set mem_rdata to 0 if a read.
REQ-022 Zero-wait SRAM latency: read = 4 cycles IDLE->REQ->WAIT_R->DONE; store = 3 cycles IDLE->REQ->DONE.

Reset
REQ-023 On rst high, immediately (asynchronously): state=IDLE, sram_req=0, sram_we=0, sram_be=0, err=0, mem_rdata=0, counter=0; dbusy follows REQ-009/016.
REQ-024 rst asserted mid-transaction SHALL abort it with no completion, err, or mem_rdata update; a pending SRAM response after release is ignored.

Verification
REQ-025 Load byte signed, addr 0x103, SRAM word 0x80FF_1234, gnt same cycle, rvalid next -> mem_rdata 0xFFFF_FF80 in DONE (cycle 3), dbusy high cycles 0-2.
REQ-026 Store half addr 0x202, wdata 0x0000_ABCD -> sram_addr 0x80, sram_wdata 0xABCD_ABCD, sram_be 4'b1100, sram_we=1, DONE on cycle 2.
REQ-027 Word load addr 0x6 -> no sram_req, err pulse 1 cycle, mem_rdata 0, dbusy low after 1 busy cycle.
REQ-028 TIMEOUT_CYCLES=4, read with sram_gnt held low -> sram_req high 4 cycles, then err pulse, mem_rdata 0, back to IDLE.
REQ-029 wmem and rdmem high together, addr 0x10 -> single store, sram_we=1, mem_rdata unchanged.
REQ-030 rst pulse while in WAIT_R, then sram_rvalid with 0x1234_5678 -> mem_rdata stays 0, state IDLE, no err.
